// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared address map, funct3 encodings and region decode for the data-memory responder
package mem_map_pkg;
    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_LO = 32'h0200_4000;
    localparam logic [31:0] MTIMECMP_HI = 32'h0200_4004;
    localparam logic [31:0] MTIME_LO    = 32'h0200_BFF8;
    localparam logic [31:0] MTIME_HI    = 32'h0200_BFFC;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {REG_RAM, REG_TIMER, REG_NONE} region_e;
    function automatic logic is_timer(input logic [31:0] a);
        return a[31:2] == MTIMECMP_LO[31:2] || a[31:2] == MTIMECMP_HI[31:2] ||
               a[31:2] == MTIME_LO[31:2] || a[31:2] == MTIME_HI[31:2];
    endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: CPU load/store port between the MEM/WB stages and the data-memory responder
interface data_mem_responder_if #(parameter int SIZE = 32);
    logic [SIZE-1:0] address;
    logic [SIZE-1:0] data;
    logic            MEM_write;
    logic [2:0]      byte_sel_mem;
    logic [SIZE-1:0] data_out;
    logic            bus_err;
    logic            timer_irq;
    modport master (output address, data, MEM_write, byte_sel_mem, input data_out, bus_err, timer_irq);
    modport slave (input address, data, MEM_write, byte_sel_mem, output data_out, bus_err, timer_irq);
endinterface

// File: rtl/mtimer.sv
// mtimer: prescaled 64-bit mtime, mtimecmp, word-wide register access and registered timer_irq compare
module mtimer
    import mem_map_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        timer_irq
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [PW-1:0] pre;
    logic [63:0] mtime, mtimecmp;
    logic tick, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi;
    assign tick = pre == PW'(TICK_DIV - 1);
    assign wr_cmp_lo  = we && address[31:2] == MTIMECMP_LO[31:2];
    assign wr_cmp_hi  = we && address[31:2] == MTIMECMP_HI[31:2];
    assign wr_time_lo = we && address[31:2] == MTIME_LO[31:2];
    assign wr_time_hi = we && address[31:2] == MTIME_HI[31:2];
    always_comb begin
        rdata = address[31:2] == MTIMECMP_LO[31:2] ? mtimecmp[31:0] :
                address[31:2] == MTIMECMP_HI[31:2] ? mtimecmp[63:32] :
                address[31:2] == MTIME_LO[31:2]    ? mtime[31:0] :
                address[31:2] == MTIME_HI[31:2]    ? mtime[63:32] : '0;
    end
    // a software write to mtime swallows a coincident tick
    always_ff @(posedge clk) begin
        if (reset) begin
            pre       <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
        end else begin
            pre       <= tick ? '0 : pre + 1'b1;
            mtime     <= wr_time_lo ? {mtime[63:32], wdata} :
                         wr_time_hi ? {wdata, mtime[31:0]} :
                         tick       ? mtime + 64'd1 : mtime;
            mtimecmp  <= wr_cmp_lo ? {mtimecmp[63:32], wdata} :
                         wr_cmp_hi ? {wdata, mtimecmp[31:0]} : mtimecmp;
            timer_irq <= mtime >= mtimecmp;
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressable RAM with 1-cycle registered loads and bus_err reporting;
// the machine timer is included when DATA_MEM_RESPONDER_TIMER_EN is defined.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int SIZE        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int TICK_DIV    = 1
) (
    input logic clk,
    input logic reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [SIZE-1:0] mem [DEPTH_WORDS];
    logic [1:0] ofs;
    logic [AW-1:0] idx;
    logic [2:0] f3;
    logic is_byte, is_half, is_word, illegal, misal, in_ram, timer_hit, wr_ok, ram_we, tmr_we, err;
    region_e region;
    logic [3:0] be;
    logic [SIZE-1:0] wdata, rd_word, tmr_rdata;
    assign ofs = bus.address[1:0];
    assign idx = bus.address[AW+1:2];
    assign f3  = bus.byte_sel_mem;
`ifdef DATA_MEM_RESPONDER_TIMER_EN
    mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
        .clk(clk), .reset(reset), .address(bus.address), .wdata(bus.data),
        .we(tmr_we), .rdata(tmr_rdata), .timer_irq(bus.timer_irq)
    );
    assign timer_hit = is_timer(bus.address);
`else
    logic unused_tick;
    assign unused_tick   = TICK_DIV != 0;
    assign tmr_rdata     = '0;
    assign timer_hit     = 1'b0;
    assign bus.timer_irq = 1'b0;
`endif
    // illegal funct3 values have f3[1] set, so loads fall through as word accesses
    always_comb begin
        is_byte = f3[1:0] == 2'b00;
        is_half = f3[1:0] == 2'b01;
        is_word = f3[1];
        illegal = f3[1] & (f3[0] | f3[2]);
        misal   = (is_half & ofs[0]) | (is_word & (ofs != 2'b00));
        in_ram  = bus.address[SIZE-1:AW+2] == '0;
        region  = in_ram ? REG_RAM : timer_hit ? REG_TIMER : REG_NONE;
        wr_ok   = bus.MEM_write & ~reset & ~misal & ~illegal;
        ram_we  = wr_ok & (region == REG_RAM);
        tmr_we  = wr_ok & (region == REG_TIMER) & is_word;
        be      = is_word ? 4'hF : (is_half ? 4'h3 : 4'h1) << ofs;
        wdata   = is_byte ? {4{bus.data[7:0]}} : is_half ? {2{bus.data[15:0]}} : bus.data;
        rd_word = region == REG_RAM ? mem[idx] : region == REG_TIMER ? tmr_rdata : '0;
        err     = (region == REG_NONE) | misal | (bus.MEM_write & illegal) |
                  ((region == REG_TIMER) & ~is_word);
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_out <= '0;
            bus.bus_err  <= 1'b0;
        end else begin
            bus.data_out <= rd_word >> {ofs, 3'b000};
            bus.bus_err  <= err;
        end
    end
endmodule
